// File: rtl/route_cam.sv
// Small CAM-style routing table: learn/delete config port plus a one-cycle
// valid/ready lookup pipe. Lookups see table state from before the same edge.
module route_cam #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned PORT_W       = 2,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DEFAULT_PORT = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  input  logic                     cfg_op,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [PORT_W-1:0]        cfg_port,
  input  logic                     lkp_valid,
  output logic                     lkp_ready,
  input  logic [ADDR_W-1:0]        lkp_addr,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [PORT_W-1:0]        res_port,
  output logic                     res_hit,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [PORT_W-1:0] DefPort = PORT_W'(DEFAULT_PORT);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PORT_W-1:0] port_q [DEPTH];
  logic [IDX_W-1:0]  repl_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic              res_valid_q;
  logic              res_hit_q;
  logic [PORT_W-1:0] res_port_q;

  logic              cfg_hit;
  logic [IDX_W-1:0]  cfg_idx;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              lkp_hit;
  logic [PORT_W-1:0] lkp_port;

  logic              wr_en;
  logic              clr_valid;
  logic [IDX_W-1:0]  wr_idx;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              repl_adv;
  logic              accept;

  // Unique-address invariant means at most one match per search.
  always_comb begin
    cfg_hit    = 1'b0;
    cfg_idx    = '0;
    lkp_hit    = 1'b0;
    lkp_port   = DefPort;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && addr_q[i] == cfg_addr) begin
        cfg_hit = 1'b1;
        cfg_idx = IDX_W'(i);
      end
      if (valid_q[i] && addr_q[i] == lkp_addr) begin
        lkp_hit  = 1'b1;
        lkp_port = port_q[i];
      end
    end
    // Descending scan leaves the lowest free index.
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    clr_valid = 1'b0;
    wr_idx    = '0;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    repl_adv  = 1'b0;
    if (cfg_valid) begin
      if (!cfg_op) begin
        wr_en = 1'b1;
        if (cfg_hit) begin
          wr_idx = cfg_idx;
        end else if (free_found) begin
          wr_idx  = free_idx;
          cnt_inc = 1'b1;
        end else begin
          wr_idx   = repl_ptr_q;
          repl_adv = 1'b1;
        end
      end else if (cfg_hit) begin
        clr_valid = 1'b1;
        wr_idx    = cfg_idx;
        cnt_dec   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      repl_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end else if (clr_valid) begin
        valid_q[wr_idx] <= 1'b0;
      end
      if (cnt_inc) begin
        count_q <= count_q + CNT_W'(1);
      end else if (cnt_dec) begin
        count_q <= count_q - CNT_W'(1);
      end
      if (repl_adv) begin
        repl_ptr_q <= repl_ptr_q + IDX_W'(1);
      end
    end
  end

  // Entry payload needs no reset; the valid bits gate it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_q[wr_idx] <= cfg_addr;
      port_q[wr_idx] <= cfg_port;
    end
  end

  assign lkp_ready = !res_valid_q || res_ready;
  assign accept    = lkp_valid && lkp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_port_q  <= DefPort;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_hit_q   <= lkp_hit;
      res_port_q  <= lkp_port;
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_hit   = res_hit_q;
  assign res_port  = res_port_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: doc/route_cam.md
ROUTE_CAM -- requirements
Module: route_cam

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter PORT_W, default 2, destination port width in bits.
REQ-003 Parameter DEPTH, default 8, number of table entries; a power of two, at least 2.
REQ-004 Parameter DEFAULT_PORT, default 0, port returned on a lookup miss.
REQ-005 Port list SHALL be:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  configuration command strobe; always accepted.
- cfg_op  input  1  0 = write/learn, 1 = delete.
- cfg_addr  input  ADDR_W  address of the command.
- cfg_port  input  PORT_W  port for a write; ignored on delete.
- lkp_valid  input  1  lookup request valid.
- lkp_ready  output  1  lookup request accepted when lkp_valid and lkp_ready are both high.
- lkp_addr  input  ADDR_W  address to look up.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumed when res_valid and res_ready are both high.
- res_port  output  PORT_W  resolved destination port.
- res_hit  output  1  1 = address found, 0 = miss.
- count  output  clog2(DEPTH)+1  number of valid entries.
- full  output  1  count == DEPTH.

Function
REQ-006 Each entry SHALL hold a valid bit, an ADDR_W address and a PORT_W port.
REQ-007 Write, address already present in a valid entry: that entry's port SHALL be updated in place; count unchanged.
REQ-008 Write, address absent, table not full: the SHALL go to the lowest-index invalid entry; count += 1.
REQ-009 Write, address absent, table full: the entry at repl_ptr SHALL be overwritten; repl_ptr then increments modulo DEPTH, wrapping from DEPTH-1 to 0; count unchanged.
REQ-010 repl_ptr SHALL change only under REQ-009.
REQ-011 Delete, address present: that entry's valid bit SHALL clear; count -= 1.
REQ-012 Delete, address absent: no state change.
REQ-013 A valid address SHALL never occupy more than one entry.
REQ-014 lkp_ready SHALL equal !res_valid || res_ready, as a combinational function of registered state and res_ready.
REQ-015 Lookup latency SHALL be one cycle: a request accepted at edge N presents res_valid, res_port and res_hit after edge N.
REQ-016 Hit: res_hit=1 and res_port = the matching entry's port.
REQ-017 Miss: res_hit=0 and res_port=DEFAULT_PORT.
REQ-018 While res_valid=1 and res_ready=0, res_port and res_hit SHALL hold stable.
REQ-019 res_valid SHALL clear after a consuming edge unless a new request is accepted on that same edge; back-to-back throughput is one lookup per cycle.
REQ-020 A lookup and a config command on the same edge: the lookup SHALL see the table contents before that edge (read-before-write).
REQ-021 Config commands SHALL never stall or be dropped, and SHALL apply regardless of lookup backpressure.

Reset
REQ-022 On reset assertion, without waiting for clk:
- all valid bits = 0
- repl_ptr = 0, count = 0, full = 0
- res_valid = 0, res_hit = 0, res_port = DEFAULT_PORT
REQ-023 Entry address and port fields need not reset.
REQ-024 Reset mid-transaction SHALL discard any pending result; the first accepted lookup after deassertion returns a miss.
REQ-025 During reset, lkp_ready SHALL be 1.

Verification
REQ-026 Reset, then write A0->1, A1->2, A2->3 -> lookup A1 gives hit=1, port=2, one cycle after accept; count=3.
REQ-027 Write A0->1, then write A0->3 -> lookup A0 gives port=3; count=1.
REQ-028 Fill 8 entries (DEPTH=8) with addresses 0x10..0x17, then write 0x20->2 -> 0x10 misses with port=0; 0x20 hits with port=2; full=1. A further write 0x21 evicts 0x11 (repl_ptr wrap check after 8 evictions).
REQ-029 Delete 0x12, then write 0x30->1 -> 0x30 fills the freed slot; repl_ptr unchanged; 0x13 still hits; delete of an absent address leaves count unchanged.
REQ-030 Hold res_ready=0 for 3 cycles with lkp_valid=1 -> lkp_ready=0 and the result is stable. Then release -> results stream one per cycle in request order.
REQ-031 Same-edge write A5->2 and lookup A5 (not previously present) -> result miss; next lookup of A5 hits with port=2. Assert reset while res_valid=1 -> res_valid drops immediately.
